// File: rtl/block_ack_tx.sv
// ============================================================================
// block_ack_tx
// ----------------------------------------------------------------------------
// Reporting stage of the flash bootstrap loader. It snoops the bytes written
// into the block buffers and keeps a running per-block checksum. Each time the
// flash writer reports a finished block, it queues a 4-byte acknowledgement
// frame (A5, index lo, index hi, checksum). At session end it queues a
// terminating frame (5A, count lo, count hi, FF). Frames go out on an 8N1 UART
// line, LSB first, with no idle gap between the four bytes.
//
// Configuration macro:
//   ACK_CRC8_EN  defined   -> checksum is CRC-8 (poly 0x07, init 0x00,
//                             MSB first, no reflection, no final XOR)
//                undefined -> checksum is the XOR of all bytes of the block
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit period (4..65535)
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   byte_en      in   pulse: byte_data is written to the block buffer
//   byte_data    in   [7:0] snooped buffer write data
//   block_full   in   pulse: current block buffer just filled
//   block_done   in   pulse: oldest filled block finished programming
//   session_end  in   pulse: host stream timed out, session over
//   tx           out  UART 8N1 line, idles high
//   busy         out  a frame is being transmitted or is pending
//   overflow     out  sticky: an acknowledgement request was dropped
// ============================================================================
module block_ack_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       byte_en,
    input  logic [7:0] byte_data,
    input  logic       block_full,
    input  logic       block_done,
    input  logic       session_end,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    // Last value of the bit-period counter before the period ends.
    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    localparam logic [7:0] TYPE_ACK = 8'hA5;
    localparam logic [7:0] TYPE_END = 8'h5A;
    localparam logic [7:0] END_TAIL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Checksum step: one byte folded into the running accumulator.
    // ------------------------------------------------------------------
    function automatic logic [7:0] acc_step(input logic [7:0] acc,
                                            input logic [7:0] data);
`ifdef ACK_CRC8_EN
        logic [7:0] crc;
        crc = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc;
`else
        return acc ^ data;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [1:0]  byte_idx_q,  byte_idx_d;
    logic [31:0] frame_q,     frame_d;      // byte 0 in [7:0], sent first

    logic [31:0] slot_q,      slot_d;       // pending frame, same layout
    logic        slot_full_q, slot_full_d;
    logic        end_seen_q,  end_seen_d;   // end frame queued: ignore requests

    logic [7:0]  acc_q,       acc_d;
    logic [7:0]  chk_q,       chk_d;        // checksum latched at block_full
    logic [15:0] blk_q,       blk_d;

    logic        tx_q,        tx_d;
    logic        busy_q,      busy_d;
    logic        ovf_q,       ovf_d;

    logic [7:0]  acc_upd_s;

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

    // Checksum accumulator: a byte arriving with block_full is part of the
    // block being closed, so the latch takes the updated value.
    always_comb begin
        if (byte_en) begin
            acc_upd_s = acc_step(acc_q, byte_data);
        end else begin
            acc_upd_s = acc_q;
        end

        if (block_full) begin
            chk_d = acc_upd_s;
            acc_d = 8'h00;
        end else begin
            chk_d = chk_q;
            acc_d = acc_upd_s;
        end
    end

    // Pending slot and request arbitration: ack wins over end in the same
    // cycle; a request arriving while the slot is occupied is dropped.
    always_comb begin
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        end_seen_d  = end_seen_q;
        blk_d       = blk_q;
        ovf_d       = ovf_q;

        // The transmitter takes the slot contents in LOAD.
        if (state_q == ST_LOAD) begin
            slot_full_d = 1'b0;
        end else begin
            slot_full_d = slot_full_q;
        end

        if (end_seen_q) begin
            // Session is closed; requests are silently ignored.
            ovf_d = ovf_q;
        end else if (block_done) begin
            if (slot_full_q) begin
                ovf_d = 1'b1;
            end else begin
                slot_d      = {chk_q, blk_q[15:8], blk_q[7:0], TYPE_ACK};
                slot_full_d = 1'b1;
                blk_d       = blk_q + 16'd1;
            end
            // A simultaneous end request always loses.
            if (session_end) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_d;
            end
        end else if (session_end) begin
            if (slot_full_q) begin
                ovf_d = 1'b1;
            end else begin
                slot_d      = {END_TAIL, blk_q[15:8], blk_q[7:0], TYPE_END};
                slot_full_d = 1'b1;
                end_seen_d  = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit FSM next state plus its bit/byte counters.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (slot_full_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                frame_d    = slot_q;
                byte_idx_d = 2'd0;
                bit_idx_d  = 3'd0;
                cnt_d      = 16'd0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = 16'd0;
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Output decode from next-state values so tx/busy can be registered
    // without adding a cycle of latency.
    always_comb begin
        busy_d = (state_d != ST_IDLE) || slot_full_d;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = frame_d[{byte_idx_d, bit_idx_d}];
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, slot, checksum and registered output flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            frame_q     <= 32'd0;
            slot_q      <= 32'd0;
            slot_full_q <= 1'b0;
            end_seen_q  <= 1'b0;
            acc_q       <= 8'h00;
            chk_q       <= 8'h00;
            blk_q       <= 16'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            frame_q     <= frame_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            end_seen_q  <= end_seen_d;
            acc_q       <= acc_d;
            chk_q       <= chk_d;
            blk_q       <= blk_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_block_ack_tx.sv
// Testbench for block_ack_tx: a UART receiver monitor decodes every byte on
// tx and compares it against an expected-byte queue filled when requests are
// issued. A vector table drives checksum blocks; hand-written sequences cover
// buffering/overflow, session end and reset during a frame.
module tb_block_ack_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       byte_en = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       block_full = 1'b0;
    logic       block_done = 1'b0;
    logic       session_end = 1'b0;
    logic       tx;
    logic       busy;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] blk_m = 16'd0;

    logic [7:0] mon_byte;
    logic [7:0] mon_exp;
    logic       mon_ok;

    typedef struct {
        int             n;
        logic [8:0][7:0] d;
        bit             same_cycle;
        logic [7:0]     exp_xor;
        logic [7:0]     exp_crc;
    } vec_t;

    vec_t vecs [5];

    block_ack_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .block_full (block_full),
        .block_done (block_done),
        .session_end(session_end),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Bit-serial CRC-8 reference (poly 0x07, MSB first).
    function automatic logic [7:0] crc_model(input logic [8:0][7:0] d, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ d[k][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] t, input logic [7:0] last);
        exp_q.push_back(t);
        exp_q.push_back(blk_m[7:0]);
        exp_q.push_back(blk_m[15:8]);
        exp_q.push_back(last);
    endtask

    // All stimulus tasks start and end right after a falling edge.
    task automatic send_byte(input logic [7:0] d, input logic full);
        byte_en    = 1'b1;
        byte_data  = d;
        block_full = full;
        @(negedge clk);
        byte_en    = 1'b0;
        block_full = 1'b0;
    endtask

    task automatic do_full();
        block_full = 1'b1;
        @(negedge clk);
        block_full = 1'b0;
    endtask

    // Issue one request and time the resulting frame; c counts edges after
    // the edge that sampled the pulse.
    task automatic send_req(input bit is_end, input logic [7:0] chk, input logic exp_ovf);
        int c, tx_at, idle_at;
        if (is_end) begin
            push_frame(8'h5A, 8'hFF);
            session_end = 1'b1;
        end else begin
            push_frame(8'hA5, chk);
            blk_m++;
            block_done = 1'b1;
        end
        @(negedge clk);
        session_end = 1'b0;
        block_done  = 1'b0;
        c = 0; tx_at = -1; idle_at = -1;
        while (c < 400 && idle_at < 0) begin
            if (tx_at < 0 && tx == 1'b0) tx_at = c;
            if (tx_at >= 0 && busy == 1'b0) idle_at = c;
            if (idle_at < 0) begin
                @(negedge clk);
                c++;
            end
        end
        check("start_latency", tx_at, 2);
        check("frame_length", idle_at - tx_at, 160);
        check("overflow_flag", {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        blk_m = 16'd0;
        exp_q.delete();
        repeat (50) @(negedge clk);
    endtask

    // UART receiver: samples each bit near its start, away from clock edges.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (n_rst && tx == 1'b0) begin
                mon_ok = 1'b1;
                for (int j = 0; j < 9; j++) begin
                    repeat (CPB) @(negedge clk);
                    if (!n_rst) mon_ok = 1'b0;
                    if (j < 8) mon_byte[j] = tx;
                    else if (mon_ok) check("stop_bit", {31'd0, tx}, 32'd1);
                end
                if (mon_ok) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL uart_byte: got %02h, expected no byte at %0t", mon_byte, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_byte !== mon_exp) begin
                            fails++;
                            $display("FAIL uart_byte: got %02h, expected %02h at %0t", mon_byte, mon_exp, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        logic [7:0] exp_chk;

        // Vector table: blocks of snooped bytes and their expected checksum.
        vecs[0].n = 3; vecs[0].same_cycle = 1'b0;
        vecs[0].d[0] = 8'h01; vecs[0].d[1] = 8'h02; vecs[0].d[2] = 8'h04;
        vecs[0].exp_xor = 8'h07; vecs[0].exp_crc = crc_model(vecs[0].d, 3);
        vecs[1].n = 9; vecs[1].same_cycle = 1'b0;
        for (int k = 0; k < 9; k++) vecs[1].d[k] = 8'h31 + 8'(k);
        vecs[1].exp_xor = 8'h31; vecs[1].exp_crc = 8'hF4;
        vecs[2].n = 0; vecs[2].same_cycle = 1'b0; vecs[2].d = '0;
        vecs[2].exp_xor = 8'h00; vecs[2].exp_crc = 8'h00;
        vecs[3].n = 3; vecs[3].same_cycle = 1'b1;
        vecs[3].d[0] = 8'h12; vecs[3].d[1] = 8'h34; vecs[3].d[2] = 8'hFF;
        vecs[3].exp_xor = 8'hD9; vecs[3].exp_crc = crc_model(vecs[3].d, 3);
        vecs[4].n = 0; vecs[4].same_cycle = 1'b0; vecs[4].d = '0;
        vecs[4].exp_xor = 8'h00; vecs[4].exp_crc = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_tx", {31'd0, tx}, 32'd1);

        // Table-driven checksum blocks, one ack each.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                send_byte(vecs[i].d[k], vecs[i].same_cycle && (k == vecs[i].n - 1));
            if (!vecs[i].same_cycle) do_full();
            @(negedge clk);
`ifdef ACK_CRC8_EN
            exp_chk = vecs[i].exp_crc;
`else
            exp_chk = vecs[i].exp_xor;
`endif
            send_req(1'b0, exp_chk, 1'b0);
        end
        repeat (60) @(negedge clk);

        // Reset during the DATA phase of a frame.
        block_done = 1'b1;
        @(negedge clk);
        block_done = 1'b0;
        repeat (20) @(negedge clk);
        pulse_reset();

        // Buffering and overflow: three requests during the first frame.
        push_frame(8'hA5, 8'h00); blk_m++;
        block_done = 1'b1;
        @(negedge clk);
        block_done = 1'b0;
        for (c = 0; c <= 330; c++) begin
            if (c == 10) begin
                push_frame(8'hA5, 8'h00); blk_m++;
                block_done = 1'b1;
            end else if (c == 15) begin
                block_done = 1'b1;
            end else begin
                block_done = 1'b0;
            end
            if (c == 5)   check("ovf_before_drop", {31'd0, overflow}, 32'd0);
            if (c == 18)  check("ovf_after_drop", {31'd0, overflow}, 32'd1);
            if (c == 163) check("gap_tx_high", {31'd0, tx}, 32'd1);
            if (c == 163) check("gap_busy", {31'd0, busy}, 32'd1);
            if (c == 164) check("b2b_start", {31'd0, tx}, 32'd0);
            if (c == 330) check("b2b_idle", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        send_req(1'b0, 8'h00, 1'b1);   // carries index 2
        repeat (60) @(negedge clk);

        // Session end after three acks, then ignored requests.
        pulse_reset();
        for (int i = 0; i < 3; i++) send_req(1'b0, 8'h00, 1'b0);
        send_req(1'b1, 8'h00, 1'b0);
        block_done = 1'b1;
        @(negedge clk);
        block_done  = 1'b0;
        session_end = 1'b1;
        @(negedge clk);
        session_end = 1'b0;
        repeat (3) @(negedge clk);
        check("after_end_busy", {31'd0, busy}, 32'd0);
        repeat (60) @(negedge clk);
        check("after_end_overflow", {31'd0, overflow}, 32'd0);
        check("after_end_tx", {31'd0, tx}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_ack_tx.md
# block_ack_tx

Downstream reporting stage for the flash bootstrap loader. It snoops the byte stream written into the block buffers and computes a per-block checksum. Once the flash writer finishes programming each block, it sends a 4-byte acknowledgement frame back to the host on the UART `tx` line. At session end it sends a terminating frame with the total block count, so the host can pace transfers and detect corruption.

## Interface
- `CLKS_PER_BIT`, default 104: clocks per UART bit (12 MHz / 115200); legal range 4..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `byte_en`  in  1  pulse; `byte_data` is being written to the block buffer this cycle.
- `byte_data`  in  8  snooped buffer write data.
- `block_full`  in  1  pulse; the current block buffer has just been filled.
- `block_done`  in  1  pulse; the flash writer has finished programming the oldest filled block.
- `session_end`  in  1  pulse; the host stream has timed out and the session is over.
- `tx`  out  1  UART 8N1 output, LSB first, idles high.
- `busy`  out  1  a frame is being transmitted or is pending.
- `overflow`  out  1  sticky; an acknowledgement request was dropped.

## Operation
- **Checksum accumulator `acc[7:0]`**
  - Updated on every `byte_en`.
  - On `block_full`, the value including any `byte_en` byte of the same cycle is latched into `chk_latched`, and `acc` restarts at 0x00.
- **Block index `blk[15:0]`**
  - Index of the next block to acknowledge; starts at 0.
  - Increments when an ack frame is accepted into the pending slot.
  - Wraps 0xFFFF to 0x0000.
- **Pending slot** (one entry: frame type plus 3 payload bytes)
  - `block_done` loads an ack frame: 0xA5, `blk[7:0]`, `blk[15:8]`, `chk_latched`.
  - `session_end` loads an end frame: 0x5A, `blk[7:0]`, `blk[15:8]`, 0xFF.
  - If the slot is already full, the request is dropped and `overflow` is set; `blk` does not advance.
  - If both pulses arrive in the same cycle, the ack is taken and the end is dropped (`overflow` set).
  - After an end frame is queued, further `block_done` and `session_end` pulses are ignored without setting `overflow` until reset.
- **Transmit FSM**
  - IDLE: `tx` = 1. If the slot is full, go to LOAD.
  - LOAD: move the slot into the shift frame, clear the slot, set `byte_idx` = 0, go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` clocks, then go to DATA.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` clocks each, then go to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` clocks. If `byte_idx` < 3, increment it and go to START; otherwise go to IDLE.
- **Status outputs**
  - `busy` = (state != IDLE) or slot full.
  - The slot can refill while a frame is transmitting, which gives one frame of buffering.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `overflow` = 0, `acc` = 0x00, `blk` = 0, slot empty, state IDLE.
- Reset is asynchronous: asserting `n_rst` mid-frame forces `tx` high immediately and discards the frame.
- Latency: `block_done` sampled at edge N gives slot full after N, LOAD after N+1, and `tx` low after edge N+2.
- A frame lasts exactly 40·`CLKS_PER_BIT` clocks, with no idle gap between bytes.
- Back-to-back frames from a full slot: 1 IDLE clock plus 1 LOAD clock between the last stop bit and the next start bit.
- The bit counter is 16 bits and counts 0..`CLKS_PER_BIT`-1.

## Configuration
- `ACK_CRC8_EN` defined:
  - `acc` is CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - One byte is processed per `byte_en`.
  - Check value: "123456789" gives 0xF4.
- `ACK_CRC8_EN` undefined: `acc` is the XOR of all bytes in the block.

## Test plan
- **Basic ack:** `CLKS_PER_BIT`=4, write bytes 0x01, 0x02, 0x04, then `block_full`, then `block_done`. Expect frame A5 00 00 07 (XOR build), 160 clocks long, `tx` low 2 clocks after `block_done`.
- **CRC build:** feed "123456789", then `block_full`, then `block_done`. Expect checksum byte 0xF4; the next empty block gives 0x00.
- **Same-cycle edge:** `byte_en`=0xFF in the same cycle as `block_full`. The 0xFF is counted in the latched checksum; the next block's accumulator starts at 0x00.
- **Buffering and overflow:** three `block_done` pulses during the first frame. Expect frames for indices 0 and 1 to be sent; the third is dropped, `overflow`=1 and sticky, `blk`=2.
- **Session end:** after 3 acks, `session_end` gives 5A 03 00 FF. A later `block_done` produces no frame and `overflow` stays 0.
- **Reset mid-frame:** drop `n_rst` during DATA. `tx`=1 asynchronously; all outputs return to reset values and the next ack uses index 0.
